// File: rtl/mvm_seq_ctrl.sv
// Batch matrix-vector read sequencer: walks w (inner), r, b (outer), issues one
// vector/matrix read per non-stalled cycle and delays accumulator flags by RD_LAT.
module mvm_seq_ctrl #(
  parameter int VEC_ADDRW = 4,
  parameter int MAT_ADDRW = 5,
  parameter int BATCHW    = 3,
  parameter int RD_LAT    = 2,
  localparam int VEC_SIZEW = VEC_ADDRW + 1,
  localparam int MAT_SIZEW = MAT_ADDRW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic [VEC_ADDRW-1:0] vec_start_addr,
  input  logic [VEC_SIZEW-1:0] vec_num_words,
  input  logic [MAT_ADDRW-1:0] mat_start_addr,
  input  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
  input  logic [BATCHW-1:0]    num_vecs,
  output logic                 rd_en,
  output logic [VEC_ADDRW-1:0] vec_raddr,
  output logic [MAT_ADDRW-1:0] mat_raddr,
  output logic                 acc_valid,
  output logic                 accum_first,
  output logic                 accum_last,
  output logic [BATCHW-1:0]    out_batch,
  output logic                 busy,
  output logic                 done
);

  localparam int DCW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t               r_state;
  logic [VEC_SIZEW-1:0] r_n;
  logic [MAT_SIZEW-1:0] r_rnum;
  logic [BATCHW-1:0]    r_bnum;
  logic [MAT_ADDRW-1:0] r_mat_start;
  logic [VEC_SIZEW-1:0] r_w;
  logic [MAT_SIZEW-1:0] r_r;
  logic [BATCHW-1:0]    r_b;
  logic [VEC_ADDRW-1:0] r_vbase;
  logic [MAT_ADDRW-1:0] r_mrow;
  logic [DCW-1:0]       r_drain_cnt;
  logic                 r_rd_en;
  logic [VEC_ADDRW-1:0] r_vec_raddr;
  logic [MAT_ADDRW-1:0] r_mat_raddr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_iss_first;
  logic                 r_iss_last;
  logic [BATCHW-1:0]    r_iss_batch;
  logic [RD_LAT-1:0]    r_pv;
  logic [RD_LAT-1:0]    r_pf;
  logic [RD_LAT-1:0]    r_pl;
  logic [BATCHW-1:0]    r_pb [RD_LAT];

  // In IDLE the element to issue is (0,0,0) taken straight from the config inputs,
  // so the first read goes out in the cycle right after start is sampled.
  logic                 w_idle;
  logic [VEC_SIZEW-1:0] w_n;
  logic [MAT_SIZEW-1:0] w_rnum;
  logic [BATCHW-1:0]    w_bnum;
  logic [MAT_ADDRW-1:0] w_mstart;
  logic [VEC_SIZEW-1:0] w_cw;
  logic [MAT_SIZEW-1:0] w_cr;
  logic [BATCHW-1:0]    w_cb;
  logic [VEC_ADDRW-1:0] w_vbase;
  logic [MAT_ADDRW-1:0] w_mrow;
  logic                 w_w_end;
  logic                 w_r_end;
  logic                 w_b_end;
  logic                 w_final;
  logic                 w_cfg_zero;
  logic                 w_issue;
  logic [VEC_ADDRW-1:0] w_vec_addr;
  logic [MAT_ADDRW-1:0] w_mat_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_n        = w_idle ? vec_num_words          : r_n;
  assign w_rnum     = w_idle ? mat_num_rows_per_olane : r_rnum;
  assign w_bnum     = w_idle ? num_vecs               : r_bnum;
  assign w_mstart   = w_idle ? mat_start_addr         : r_mat_start;
  assign w_cw       = w_idle ? '0                     : r_w;
  assign w_cr       = w_idle ? '0                     : r_r;
  assign w_cb       = w_idle ? '0                     : r_b;
  assign w_vbase    = w_idle ? vec_start_addr         : r_vbase;
  assign w_mrow     = w_idle ? mat_start_addr         : r_mrow;
  assign w_w_end    = (w_cw == w_n - VEC_SIZEW'(1));
  assign w_r_end    = (w_cr == w_rnum - MAT_SIZEW'(1));
  assign w_b_end    = (w_cb == w_bnum - BATCHW'(1));
  assign w_final    = w_w_end & w_r_end & w_b_end;
  assign w_cfg_zero = (vec_num_words == '0) | (mat_num_rows_per_olane == '0) | (num_vecs == '0);
  assign w_issue    = (w_idle & start & ~w_cfg_zero) | ((r_state == S_RUN) & ~stall);
  assign w_vec_addr = w_vbase + VEC_ADDRW'(w_cw);
  assign w_mat_addr = w_mrow + MAT_ADDRW'(w_cw);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_rnum      <= '0;
      r_bnum      <= '0;
      r_mat_start <= '0;
      r_w         <= '0;
      r_r         <= '0;
      r_b         <= '0;
      r_vbase     <= '0;
      r_mrow      <= '0;
      r_drain_cnt <= '0;
      r_rd_en     <= 1'b0;
      r_vec_raddr <= '0;
      r_mat_raddr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_iss_first <= 1'b0;
      r_iss_last  <= 1'b0;
      r_iss_batch <= '0;
    end else begin
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_iss_first <= 1'b0;
      r_iss_last  <= 1'b0;
      r_iss_batch <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n         <= vec_num_words;
            r_rnum      <= mat_num_rows_per_olane;
            r_bnum      <= num_vecs;
            r_mat_start <= mat_start_addr;
            if (w_cfg_zero) r_done <= 1'b1;
          end
        end
        S_RUN: ;
        S_DRAIN: begin
          // Last issue plus RD_LAT cycles: busy covers the final acc_valid cycle.
          if (r_drain_cnt == DCW'(RD_LAT)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) begin
        r_rd_en     <= 1'b1;
        r_busy      <= 1'b1;
        r_vec_raddr <= w_vec_addr;
        r_mat_raddr <= w_mat_addr;
        r_iss_first <= (w_cw == '0);
        r_iss_last  <= w_w_end;
        r_iss_batch <= w_cb;
        r_r         <= w_cr;
        r_b         <= w_cb;
        r_vbase     <= w_vbase;
        r_mrow      <= w_mrow;
        if (w_final) begin
          r_state     <= S_DRAIN;
          r_drain_cnt <= '0;
        end else begin
          r_state <= S_RUN;
        end
        if (!w_w_end) begin
          r_w <= w_cw + VEC_SIZEW'(1);
        end else begin
          r_w <= '0;
          if (!w_r_end) begin
            r_r    <= w_cr + MAT_SIZEW'(1);
            r_mrow <= w_mrow + MAT_ADDRW'(w_n);
          end else begin
            r_r     <= '0;
            r_mrow  <= w_mstart;
            r_b     <= w_cb + BATCHW'(1);
            r_vbase <= w_vbase + VEC_ADDRW'(w_n);
          end
        end
      end
    end
  end

  // Flag pipe advances every cycle, so stalled cycles travel down as bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      r_pf <= '0;
      r_pl <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pb[i] <= '0;
    end else begin
      r_pv[0] <= r_rd_en;
      r_pf[0] <= r_iss_first;
      r_pl[0] <= r_iss_last;
      r_pb[0] <= r_iss_batch;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pf[i] <= r_pf[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign rd_en       = r_rd_en;
  assign vec_raddr   = r_vec_raddr;
  assign mat_raddr   = r_mat_raddr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign acc_valid   = r_pv[RD_LAT-1];
  assign accum_first = r_pf[RD_LAT-1];
  assign accum_last  = r_pl[RD_LAT-1];
  assign out_batch   = r_pb[RD_LAT-1];

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Bench for mvm_seq_ctrl: a per-cycle timeline derived from the nested w/r/b
// iteration order is compared against the DUT, plus literal sequence pins.
module tb_mvm_seq_ctrl;
  localparam int LAT  = 2;
  localparam int MAXC = 64;

  logic       clk, rst, start, stall;
  logic [3:0] vec_start_addr;
  logic [4:0] vec_num_words;
  logic [4:0] mat_start_addr;
  logic [5:0] mat_num_rows_per_olane;
  logic [2:0] num_vecs;
  logic       rd_en, acc_valid, accum_first, accum_last, busy, done;
  logic [3:0] vec_raddr;
  logic [4:0] mat_raddr;
  logic [2:0] out_batch;

  mvm_seq_ctrl #(.VEC_ADDRW(4), .MAT_ADDRW(5), .BATCHW(3), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .vec_start_addr(vec_start_addr), .vec_num_words(vec_num_words),
    .mat_start_addr(mat_start_addr), .mat_num_rows_per_olane(mat_num_rows_per_olane),
    .num_vecs(num_vecs), .rd_en(rd_en), .vec_raddr(vec_raddr), .mat_raddr(mat_raddr),
    .acc_valid(acc_valid), .accum_first(accum_first), .accum_last(accum_last),
    .out_batch(out_batch), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int e_rd [MAXC], e_vec [MAXC], e_mat [MAXC], e_busy [MAXC], e_done [MAXC];
  int e_av [MAXC], e_af [MAXC], e_al [MAXC], e_ob [MAXC];
  int stall_plan [MAXC];
  int start_at;
  int ncyc, cc;
  bit chk_en;
  int hold_vec, hold_mat;
  int n_valid, n_done, n_busy, n_fl;
  int q_vec[$], q_mat[$], q_ob[$];

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cc, act, exp);
    end
  endtask

  task automatic check_seq(string nm, int got[$], int exp[8], int len);
    check({nm, "_len"}, got.size(), len);
    for (int i = 0; i < len && i < got.size(); i++) check($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  task automatic check_all_zero(string nm);
    check({nm, "_rd_en"}, int'(rd_en), 0);
    check({nm, "_vec"}, int'(vec_raddr), 0);
    check({nm, "_mat"}, int'(mat_raddr), 0);
    check({nm, "_acc_valid"}, int'(acc_valid), 0);
    check({nm, "_first"}, int'(accum_first), 0);
    check({nm, "_last"}, int'(accum_last), 0);
    check({nm, "_batch"}, int'(out_batch), 0);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_done"}, int'(done), 0);
  endtask

  // Expected timeline: elements are visited b-outer, r-middle, w-inner; cycle 1 is the
  // first cycle after the start edge; a stall seen during cycle c-1 removes the issue in c.
  task automatic build_model(int n, int r, int b, int vs, int ms);
    int el_v [MAXC], el_m [MAXC], el_f [MAXC], el_l [MAXC], el_b [MAXC];
    int i_f [MAXC], i_l [MAXC], i_b [MAXC];
    int t, idx, last, pv, pm;
    t = 0;
    for (int bb = 0; bb < b; bb++)
      for (int rr = 0; rr < r; rr++)
        for (int ww = 0; ww < n; ww++) begin
          el_v[t] = (vs + bb * n + ww) % 16;
          el_m[t] = (ms + rr * n + ww) % 32;
          el_f[t] = (ww == 0) ? 1 : 0;
          el_l[t] = (ww == n - 1) ? 1 : 0;
          el_b[t] = bb;
          t++;
        end
    idx = 0; last = 0; pv = hold_vec; pm = hold_mat;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_av[c] = 0; e_af[c] = 0; e_al[c] = 0;
      e_ob[c] = 0; i_f[c] = 0; i_l[c] = 0; i_b[c] = 0;
      if (c >= 1 && idx < t && (c == 1 || stall_plan[c-1] == 0)) begin
        e_rd[c] = 1; pv = el_v[idx]; pm = el_m[idx];
        i_f[c] = el_f[idx]; i_l[c] = el_l[idx]; i_b[c] = el_b[idx];
        idx++; last = c;
      end
      e_vec[c] = pv; e_mat[c] = pm;
      if (c > LAT && e_rd[c-LAT] == 1) begin
        e_av[c] = 1; e_af[c] = i_f[c-LAT]; e_al[c] = i_l[c-LAT]; e_ob[c] = i_b[c-LAT];
      end
    end
    if (t == 0) begin
      e_done[1] = 1;
      ncyc = 3;
    end else begin
      for (int c = 1; c <= last + LAT; c++) e_busy[c] = 1;
      e_done[last + LAT + 1] = 1;
      ncyc = last + LAT + 2;
    end
    hold_vec = e_vec[ncyc];
    hold_mat = e_mat[ncyc];
  endtask

  always @(negedge clk) begin
    if (chk_en && cc >= 1 && cc <= ncyc) begin
      check("rd_en", int'(rd_en), e_rd[cc]);
      check("vec_raddr", int'(vec_raddr), e_vec[cc]);
      check("mat_raddr", int'(mat_raddr), e_mat[cc]);
      check("busy", int'(busy), e_busy[cc]);
      check("done", int'(done), e_done[cc]);
      check("acc_valid", int'(acc_valid), e_av[cc]);
      check("accum_first", int'(accum_first), e_af[cc]);
      check("accum_last", int'(accum_last), e_al[cc]);
      if (e_av[cc] == 1) check("out_batch", int'(out_batch), e_ob[cc]);
      if (rd_en) begin q_vec.push_back(int'(vec_raddr)); q_mat.push_back(int'(mat_raddr)); end
      if (acc_valid) begin n_valid++; q_ob.push_back(int'(out_batch)); end
      if (acc_valid && accum_first && accum_last) n_fl++;
      if (done) n_done++;
      if (busy) n_busy++;
    end
  end

  task automatic run_case(string nm, int n, int r, int b, int vs, int ms);
    build_model(n, r, b, vs, ms);
    q_vec.delete(); q_mat.delete(); q_ob.delete();
    n_valid = 0; n_done = 0; n_busy = 0; n_fl = 0;
    vec_start_addr = 4'(vs); vec_num_words = 5'(n); mat_start_addr = 5'(ms);
    mat_num_rows_per_olane = 6'(r); num_vecs = 3'(b);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Config changes while busy must not disturb the run.
    vec_start_addr = 4'd9; vec_num_words = 5'd7; mat_start_addr = 5'd3;
    mat_num_rows_per_olane = 6'd5; num_vecs = 3'd6;
    cc = 1; chk_en = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      stall = (stall_plan[c] != 0);
      start = (c == start_at);
      @(posedge clk); #1;
      cc = c + 1;
    end
    chk_en = 1'b0; stall = 1'b0; start = 1'b0;
    $display("case %s N=%0d R=%0d B=%0d: valid=%0d done=%0d busy_cycles=%0d", nm, n, r, b, n_valid, n_done, n_busy);
  endtask

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) stall_plan[c] = 0;
    start_at = -1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; chk_en = 1'b0; cc = 0; ncyc = 0;
    vec_start_addr = '0; vec_num_words = '0; mat_start_addr = '0;
    mat_num_rows_per_olane = '0; num_vecs = '0;
    hold_vec = 0; hold_mat = 0;
    clear_plan();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_case("basic", 3, 2, 1, 0, 0);
    check_seq("c1_vec", q_vec, '{0, 1, 2, 0, 1, 2, 0, 0}, 6);
    check_seq("c1_mat", q_mat, '{0, 1, 2, 3, 4, 5, 0, 0}, 6);
    check("c1_valid_count", n_valid, 6);
    check("c1_done_count", n_done, 1);
    check("c1_busy_cycles", n_busy, 8);

    run_case("batch", 2, 2, 2, 4, 8);
    check_seq("c2_vec", q_vec, '{4, 5, 4, 5, 6, 7, 6, 7}, 8);
    check_seq("c2_mat", q_mat, '{8, 9, 10, 11, 8, 9, 10, 11}, 8);
    check_seq("c2_batch", q_ob, '{0, 0, 0, 0, 1, 1, 1, 1}, 8);

    clear_plan();
    stall_plan[1] = 1; stall_plan[2] = 1; stall_plan[8] = 1; stall_plan[9] = 1;
    run_case("stall", 3, 2, 1, 0, 0);
    check_seq("c3_mat", q_mat, '{0, 1, 2, 3, 4, 5, 0, 0}, 6);
    check("c3_busy_cycles", n_busy, 10);
    check("c3_valid_count", n_valid, 6);
    clear_plan();

    run_case("n1", 1, 3, 1, 2, 5);
    check("c4_first_and_last", n_fl, 3);
    run_case("zero", 0, 3, 1, 0, 0);
    check("c4z_busy_cycles", n_busy, 0);
    check("c4z_issues", q_vec.size(), 0);
    check("c4z_done_count", n_done, 1);

    run_case("wrap", 3, 1, 1, 14, 30);
    check_seq("c5_vec", q_vec, '{14, 15, 0, 0, 0, 0, 0, 0}, 3);
    check_seq("c5_mat", q_mat, '{30, 31, 0, 0, 0, 0, 0, 0}, 3);

    start_at = 3;
    run_case("restart_ignored", 3, 2, 1, 0, 0);
    check("c6_valid_count", n_valid, 6);
    check("c6_done_count", n_done, 1);
    clear_plan();

    // Reset in the middle of a run.
    vec_start_addr = 4'd5; vec_num_words = 5'd3; mat_start_addr = 5'd7;
    mat_num_rows_per_olane = 6'd2; num_vecs = 3'd1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midreset_no_done", n_done, 0);
    hold_vec = 0; hold_mat = 0;
    run_case("after_reset", 3, 2, 1, 0, 0);
    check_seq("c6r_vec", q_vec, '{0, 1, 2, 0, 1, 2, 0, 0}, 6);
    check("c6r_done_count", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout (cycle %0d): got 0, expected 1", cc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mvm_seq_ctrl.md
Name: mvm_seq_ctrl

Overview:
Parametrised successor to the MVM engine controller. Sequences vector/matrix memory reads for a batch of input vectors against one matrix tile, reusing the matrix once per vector. Issues a read enable and address pair per cycle, supports stalls, and delays the accumulator control flags by a configurable read latency so they align with memory data. Sits between the host config registers and the vector/matrix BRAMs plus accumulator lanes.

Parameters:
VEC_ADDRW, 4, vector memory address width; VEC_SIZEW = VEC_ADDRW+1
MAT_ADDRW, 5, matrix memory address width; MAT_SIZEW = MAT_ADDRW+1
BATCHW, 3, width of batch count
RD_LAT, 2, memory read latency in cycles, ≥1; flag delay depth

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  launch pulse; sampled only in IDLE
stall  in  1  suppresses issue this cycle
vec_start_addr  in  VEC_ADDRW  vector base for batch 0
vec_num_words  in  VEC_SIZEW  words per vector (N)
mat_start_addr  in  MAT_ADDRW  matrix base
mat_num_rows_per_olane  in  MAT_SIZEW  rows per output lane (R)
num_vecs  in  BATCHW  vectors in batch (B)
rd_en  out  1  memory read enable (issue strobe)
vec_raddr  out  VEC_ADDRW  vector read address
mat_raddr  out  MAT_ADDRW  matrix read address
acc_valid  out  1  element valid at accumulator, RD_LAT after issue
accum_first  out  1  first element of a row, aligned with acc_valid
accum_last  out  1  last element of a row, aligned with acc_valid
out_batch  out  BATCHW  batch index of element, aligned with acc_valid
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- All outputs registered. On reset: state IDLE; every output 0; counters and delay pipe cleared.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches all config. If N, R or B is 0: no issue, busy stays 0, done=1 the following cycle. Otherwise go to RUN and set busy=1 the following cycle.
- RUN: the first issue is in the cycle after start is sampled. Counters are w (0..N-1, inner), r (0..R-1), b (0..B-1, outer).
- Each non-stalled RUN cycle drives rd_en=1 with:
  - vec_raddr = vbase + w
  - mat_raddr = mat_start_addr + r*N + w
  - vbase = vec_start_addr + b*N
- All address arithmetic wraps modulo 2^ADDRW. mat_raddr restarts at mat_start_addr for each b.
- Issue flags: first=(w==0), last=(w==N-1). N=1 gives both flags on the same element.
- stall=1 in RUN: rd_en=0, all counters hold, addresses hold their last values. The delay pipe still advances, so a bubble (valid=0) is inserted.
- Delay pipe: RD_LAT-stage shift register of {valid, first, last, b}. It feeds acc_valid/accum_first/accum_last/out_batch. accum_first and accum_last are 0 whenever acc_valid=0.
- After the final issue (w=N-1, r=R-1, b=B-1), go to DRAIN. rd_en=0.
- DRAIN: hold for RD_LAT cycles until the pipe is empty, then go to IDLE. busy falls and done=1 in that same cycle.
- Total issue count is N*R*B. busy spans from the first issue cycle through the last acc_valid cycle inclusive.
- start while busy: ignored. Config inputs may change while busy without effect.
- Reset mid-operation: the next edge returns to IDLE with all outputs 0. done is not pulsed.
- stall in IDLE/DRAIN: no effect.

Test Plan:
1. N=3, R=2, B=1, bases 0, RD_LAT=2, no stall -> rd_en for 6 cycles; mat_raddr 0..5; vec_raddr 0,1,2,0,1,2. acc_valid 2 cycles later with first at elements 0,3 and last at 2,5. done once, busy falls with done.
2. N=2, R=2, B=2, vec_start=4, mat_start=8 -> vec_raddr 4,5,4,5,6,7,6,7; mat_raddr 8..11 twice; out_batch 0×4 then 1×4; 8 acc_valid.
3. Case 1 with stall high on issue cycles 2 and 3 -> addresses frozen, rd_en=0 for 2 cycles, 2-cycle gap in acc_valid. Sequence and flags unchanged, busy extended by 2.
4. N=1, R=3, B=1 -> accum_first=accum_last=1 on all 3 valid elements. Then N=0 start -> busy never rises, done pulse next cycle, rd_en stays 0.
5. vec_start=14 (VEC_ADDRW=4), N=3, mat_start=30, R=1 -> vec_raddr 14,15,0; mat_raddr 30,31,0 (wrap).
6. start pulsed mid-RUN -> ignored, counts unchanged. rst asserted mid-RUN -> next cycle all outputs 0, no done; a fresh start then runs case 1 correctly.
